// File: rtl/mips_pkg.sv
// mips_pkg: load-type encodings shared by the MEM/WB datapath.
package mips_pkg;
  localparam int LOAD_TYPE_W = 3;
  typedef enum logic [LOAD_TYPE_W-1:0] {
    LT_LW  = 3'd0,
    LT_LB  = 3'd1,
    LT_LBU = 3'd2,
    LT_LH  = 3'd3,
    LT_LHU = 3'd4
  } load_type_e;
endpackage

// File: rtl/load_align.sv
// load_align: extracts and extends a byte/halfword from a memory word and flags misaligned loads.
// Ports: word (memory word), addr_lo (address bits 1:0), load_type -> value (extended load), misaligned.
module load_align
  import mips_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [31:0]            word,
  input  logic [1:0]             addr_lo,
  input  logic [LOAD_TYPE_W-1:0] load_type,
  output logic [31:0]            value,
  output logic                   misaligned
);
  logic [1:0]  w_byte_idx;
  logic        w_half_idx;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_is_byte;
  logic        w_is_half;
  logic        w_signed;
  // Big-endian puts byte/half 0 in the most significant lane, so invert the lane index.
  assign w_byte_idx = BIG_ENDIAN ? ~addr_lo : addr_lo;
  assign w_half_idx = BIG_ENDIAN ? ~addr_lo[1] : addr_lo[1];
  assign w_byte     = word[{w_byte_idx, 3'b000} +: 8];
  assign w_half     = word[{w_half_idx, 4'b0000} +: 16];
  // Codes 5-7 fall through to the full-word path, matching LW.
  assign w_is_byte  = (load_type == LT_LB) || (load_type == LT_LBU);
  assign w_is_half  = (load_type == LT_LH) || (load_type == LT_LHU);
  assign w_signed   = (load_type == LT_LB) || (load_type == LT_LH);
  always_comb begin
    value      = w_is_byte ? {{24{w_signed & w_byte[7]}}, w_byte}
               : w_is_half ? {{16{w_signed & w_half[15]}}, w_half}
               : word;
    misaligned = w_is_byte ? 1'b0 : w_is_half ? addr_lo[0] : |addr_lo;
  end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with load extraction and misaligned-load detection.
// Ports: clk, rst_n (async, active-low), stall, flush, in_valid, result, mem_data,
//        mem_to_reg, reg_write, write_reg, load_type -> wb_valid, wb_reg_write,
//        wb_write_reg, wb_data, misalign_err.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [31:0]            result,
  input  logic [31:0]            mem_data,
  input  logic                   mem_to_reg,
  input  logic                   reg_write,
  input  logic [4:0]             write_reg,
  input  logic [LOAD_TYPE_W-1:0] load_type,
  output logic                   wb_valid,
  output logic                   wb_reg_write,
  output logic [4:0]             wb_write_reg,
  output logic [31:0]            wb_data,
  output logic                   misalign_err
);
  logic [31:0] w_load_value;
  logic        w_align_bad;
  logic        w_misaligned;
  logic        r_valid;
  logic        r_reg_write;
  logic [4:0]  r_write_reg;
  logic [31:0] r_data;
  logic        r_misalign;
  load_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_load_align (
    .word       (mem_data),
    .addr_lo    (result[1:0]),
    .load_type  (load_type),
    .value      (w_load_value),
    .misaligned (w_align_bad)
  );
  // Alignment only matters for a real load instruction.
  assign w_misaligned = in_valid & mem_to_reg & w_align_bad;
  // Flush beats stall; a stall holds everything but lets the error pulse drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_write_reg <= 5'd0;
      r_data      <= 32'd0;
      r_misalign  <= 1'b0;
    end else if (flush) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_misalign  <= 1'b0;
    end else if (stall) begin
      r_misalign  <= 1'b0;
    end else begin
      r_valid     <= in_valid;
      r_reg_write <= in_valid & reg_write & (write_reg != 5'd0) & ~w_misaligned;
      r_write_reg <= write_reg;
      r_data      <= mem_to_reg ? w_load_value : result;
      r_misalign  <= w_misaligned;
    end
  end
  assign wb_valid     = r_valid;
  assign wb_reg_write = r_reg_write;
  assign wb_write_reg = r_write_reg;
  assign wb_data      = r_data;
  assign misalign_err = r_misalign;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed self-checking bench for mem_wb_stage (big-endian default).
module tb_mem_wb_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] result = 32'd0;
  logic [31:0] mem_data = 32'd0;
  logic        mem_to_reg = 1'b0;
  logic        reg_write = 1'b0;
  logic [4:0]  write_reg = 5'd0;
  logic [2:0]  load_type = 3'd0;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_data;
  logic        misalign_err;
  int n_checks = 0;
  int n_fail = 0;

  mem_wb_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .in_valid     (in_valid),
    .result       (result),
    .mem_data     (mem_data),
    .mem_to_reg   (mem_to_reg),
    .reg_write    (reg_write),
    .write_reg    (write_reg),
    .load_type    (load_type),
    .wb_valid     (wb_valid),
    .wb_reg_write (wb_reg_write),
    .wb_write_reg (wb_write_reg),
    .wb_data      (wb_data),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic m2r, input logic rw, input logic [4:0] wr,
                       input logic [2:0] lt, input logic [31:0] res, input logic [31:0] md);
    in_valid = v; mem_to_reg = m2r; reg_write = rw; write_reg = wr;
    load_type = lt; result = res; mem_data = md;
  endtask

  task automatic test_reset;
    drive(1'b1, 1'b0, 1'b1, 5'd3, 3'd0, 32'h0000_0055, 32'd0);
    #1;
    n_checks++;
    if ({wb_valid, wb_reg_write, wb_write_reg, wb_data, misalign_err} !== 40'd0) begin
      n_fail++; $display("FAIL reset_initial: outputs=%h expected 0", {wb_valid, wb_reg_write, wb_write_reg, wb_data, misalign_err});
    end
    @(negedge clk); rst_n = 1'b1;
    tick;
    n_checks++;
    if ({wb_valid, wb_reg_write, wb_write_reg, wb_data} !== {1'b1, 1'b1, 5'd3, 32'h0000_0055}) begin
      n_fail++; $display("FAIL first_after_reset: v=%b rw=%b wr=%0d data=%h expected 1 1 3 00000055", wb_valid, wb_reg_write, wb_write_reg, wb_data);
    end
    stall = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 5'd9, 3'd0, 32'h0000_0077, 32'd0);
    tick;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({wb_valid, wb_reg_write, wb_write_reg, wb_data, misalign_err} !== 40'd0) begin
      n_fail++; $display("FAIL reset_async_mid_stall: outputs=%h expected 0", {wb_valid, wb_reg_write, wb_write_reg, wb_data, misalign_err});
    end
    @(negedge clk); rst_n = 1'b1; stall = 1'b0;
    tick;
    n_checks++;
    if ({wb_valid, wb_write_reg, wb_data} !== {1'b1, 5'd9, 32'h0000_0077}) begin
      n_fail++; $display("FAIL edge_after_release: v=%b wr=%0d data=%h expected 1 9 00000077", wb_valid, wb_write_reg, wb_data);
    end
  endtask

  task automatic test_lb;
    logic [2:0]  lts [4] = '{3'd1, 3'd1, 3'd1, 3'd2};
    logic [31:0] adr [4] = '{32'h1004, 32'h1005, 32'h1007, 32'h1005};
    logic [31:0] exp [4] = '{32'hFFFF_FF80, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_00FF};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, 5'd5, lts[i], adr[i], 32'h80FF_7F01);
      tick;
      n_checks++;
      if (wb_data !== exp[i] || wb_reg_write !== 1'b1 || misalign_err !== 1'b0) begin
        n_fail++; $display("FAIL byte_load_%0d: data=%h rw=%b err=%b expected %h 1 0", i, wb_data, wb_reg_write, misalign_err, exp[i]);
      end
    end
  endtask

  task automatic test_lh;
    drive(1'b1, 1'b1, 1'b1, 5'd6, 3'd3, 32'h2002, 32'h8001_ABCD);
    tick;
    n_checks++;
    if (wb_data !== 32'hFFFF_ABCD) begin
      n_fail++; $display("FAIL lh_2002: data=%h expected FFFFABCD", wb_data);
    end
    drive(1'b1, 1'b1, 1'b1, 5'd6, 3'd4, 32'h2002, 32'h8001_ABCD);
    tick;
    n_checks++;
    if (wb_data !== 32'h0000_ABCD) begin
      n_fail++; $display("FAIL lhu_2002: data=%h expected 0000ABCD", wb_data);
    end
    drive(1'b1, 1'b1, 1'b1, 5'd6, 3'd4, 32'h2000, 32'h8001_ABCD);
    tick;
    n_checks++;
    if (wb_data !== 32'h0000_8001 || wb_reg_write !== 1'b1) begin
      n_fail++; $display("FAIL lhu_2000: data=%h rw=%b expected 00008001 1", wb_data, wb_reg_write);
    end
    drive(1'b1, 1'b1, 1'b1, 5'd6, 3'd3, 32'h2001, 32'h8001_ABCD);
    tick;
    n_checks++;
    if (misalign_err !== 1'b1 || wb_reg_write !== 1'b0 || wb_valid !== 1'b1) begin
      n_fail++; $display("FAIL lh_misaligned: err=%b rw=%b v=%b expected 1 0 1", misalign_err, wb_reg_write, wb_valid);
    end
    drive(1'b1, 1'b0, 1'b1, 5'd6, 3'd0, 32'h0000_0010, 32'd0);
    tick;
    n_checks++;
    if (misalign_err !== 1'b0 || wb_reg_write !== 1'b1) begin
      n_fail++; $display("FAIL misalign_pulse_end: err=%b rw=%b expected 0 1", misalign_err, wb_reg_write);
    end
    drive(1'b1, 1'b1, 1'b1, 5'd6, 3'd6, 32'h3002, 32'hCAFE_F00D);
    tick;
    n_checks++;
    if (misalign_err !== 1'b1 || wb_reg_write !== 1'b0) begin
      n_fail++; $display("FAIL code6_misaligned: err=%b rw=%b expected 1 0", misalign_err, wb_reg_write);
    end
    drive(1'b1, 1'b1, 1'b1, 5'd6, 3'd7, 32'h3004, 32'hCAFE_F00D);
    tick;
    n_checks++;
    if (wb_data !== 32'hCAFE_F00D || misalign_err !== 1'b0 || wb_reg_write !== 1'b1) begin
      n_fail++; $display("FAIL code7_as_lw: data=%h err=%b rw=%b expected CAFEF00D 0 1", wb_data, misalign_err, wb_reg_write);
    end
    drive(1'b0, 1'b1, 1'b1, 5'd6, 3'd0, 32'h3001, 32'h1111_2222);
    tick;
    n_checks++;
    if (wb_valid !== 1'b0 || wb_reg_write !== 1'b0 || misalign_err !== 1'b0) begin
      n_fail++; $display("FAIL invalid_slot: v=%b rw=%b err=%b expected 0 0 0", wb_valid, wb_reg_write, misalign_err);
    end
  endtask

  task automatic test_stall_flush;
    drive(1'b1, 1'b1, 1'b1, 5'd7, 3'd0, 32'h4001, 32'hA5A5_0001);
    tick;
    n_checks++;
    if (misalign_err !== 1'b1 || wb_data !== 32'hA5A5_0001 || wb_valid !== 1'b1) begin
      n_fail++; $display("FAIL pre_stall: err=%b data=%h v=%b expected 1 A5A50001 1", misalign_err, wb_data, wb_valid);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 5'(10 + i), 3'd0, 32'h9000_0000 + 32'(i), 32'd0);
      tick;
      n_checks++;
      if ({wb_valid, wb_reg_write, wb_write_reg, wb_data, misalign_err} !== {1'b1, 1'b0, 5'd7, 32'hA5A5_0001, 1'b0}) begin
        n_fail++; $display("FAIL stall_hold_%0d: v=%b rw=%b wr=%0d data=%h err=%b expected 1 0 7 A5A50001 0", i, wb_valid, wb_reg_write, wb_write_reg, wb_data, misalign_err);
      end
    end
    drive(1'b1, 1'b0, 1'b1, 5'd12, 3'd0, 32'h0000_1234, 32'd0);
    stall = 1'b0;
    tick;
    n_checks++;
    if (wb_valid !== 1'b1 || wb_reg_write !== 1'b1 || wb_data !== 32'h0000_1234) begin
      n_fail++; $display("FAIL unstall_load: v=%b rw=%b data=%h expected 1 1 00001234", wb_valid, wb_reg_write, wb_data);
    end
    stall = 1'b1; flush = 1'b1;
    tick;
    n_checks++;
    if (wb_valid !== 1'b0 || wb_reg_write !== 1'b0 || misalign_err !== 1'b0) begin
      n_fail++; $display("FAIL stall_flush: v=%b rw=%b err=%b expected 0 0 0", wb_valid, wb_reg_write, misalign_err);
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reg0;
    drive(1'b1, 1'b0, 1'b1, 5'd0, 3'd0, 32'hDEAD_BEEF, 32'd0);
    tick;
    n_checks++;
    if (wb_reg_write !== 1'b0 || wb_data !== 32'hDEAD_BEEF || wb_valid !== 1'b1) begin
      n_fail++; $display("FAIL reg0: rw=%b data=%h v=%b expected 0 DEADBEEF 1", wb_reg_write, wb_data, wb_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp [3] = '{32'h1111_2222, 32'h1234_5678, 32'h3333_4444};
    drive(1'b1, 1'b0, 1'b1, 5'd1, 3'd0, 32'h1111_2222, 32'd0);
    tick;
    n_checks++;
    if (wb_data !== exp[0]) begin
      n_fail++; $display("FAIL b2b_0: data=%h expected %h", wb_data, exp[0]);
    end
    drive(1'b1, 1'b1, 1'b1, 5'd2, 3'd0, 32'h3000, 32'h1234_5678);
    tick;
    n_checks++;
    if (wb_data !== exp[1] || wb_write_reg !== 5'd2) begin
      n_fail++; $display("FAIL b2b_1: data=%h wr=%0d expected %h 2", wb_data, wb_write_reg, exp[1]);
    end
    drive(1'b1, 1'b0, 1'b1, 5'd3, 3'd0, 32'h3333_4444, 32'd0);
    tick;
    n_checks++;
    if (wb_data !== exp[2] || wb_write_reg !== 5'd3) begin
      n_fail++; $display("FAIL b2b_2: data=%h wr=%0d expected %h 3", wb_data, wb_write_reg, exp[2]);
    end
  endtask

  initial begin
    test_reset;
    test_lb;
    test_lh;
    test_stall_flush;
    test_reg0;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
